hlsm_array_loader: RTL

High-level state machine that fills the 256 x 8 register file consumed by the max/min-difference datapath. It accepts bytes over a valid/ready stream, or generates an address-ramp pattern, and drives the register file write port with W_Addr, W_en and W_Data. It also keeps a modulo-256 checksum of everything written and pulses `done` after the 256th write. This block is the writer side of the register file; the max/min block is the reader.

---
 rtl/hlsm_array_loader.sv | 86 ++++++++
 1 files changed

// File: rtl/hlsm_array_loader.sv
// Writer side of the 256x8 register file: stream load or address-ramp fill.
// Tracks a byte count and a mod-256 checksum, pulses done after write 256.
module hlsm_array_loader (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       go,
    input  logic       mode,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] W_Addr,
    output logic       W_en,
    output logic [7:0] W_Data,
    output logic       busy,
    output logic [8:0] count,
    output logic [7:0] checksum,
    output logic       done
);

    typedef enum logic [1:0] {
        S_Wait,
        S_Load,
        S_Done
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [8:0] i;
    logic [7:0] sum;
    logic       mode_r;

    assign count    = i;
    assign checksum = sum;

    // State, index, checksum and latched mode registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= S_Wait;
            i      <= 9'd0;
            sum    <= 8'd0;
            mode_r <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_Wait && go) begin
                i      <= 9'd0;
                sum    <= 8'd0;
                mode_r <= mode;
            end else if (W_en) begin
                i   <= i + 9'd1;
                sum <= sum + W_Data;
            end
        end
    end

    // Next-state logic and same-cycle write port / handshake outputs
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        W_en     = 1'b0;
        W_Addr   = i[7:0];
        W_Data   = 8'd0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_Wait: begin
                if (go)
                    state_n = S_Load;
            end
            S_Load: begin
                busy     = 1'b1;
                in_ready = ~mode_r;
                W_en     = mode_r | in_valid;
                if (W_en)
                    W_Data = mode_r ? i[7:0] : in_data;
                if (W_en && i == 9'd255)
                    state_n = S_Done;
            end
            S_Done: begin
                done    = 1'b1;
                state_n = S_Wait;
            end
            default: state_n = S_Wait;
        endcase
    end

endmodule
